// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit seven-segment display path.
// Segment patterns are gfedcba, active-high; codes A..F decode to blank.
package seg_pkg;

  localparam logic [3:0] BLANK_BCD = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side load handshake for the display scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    blank_lz;
  logic                    ack;

  modport master (output load, output digits_in, output blank_lz, input ack);
  modport slave  (input load, input digits_in, input blank_lz, output ack);
endinterface

// File: rtl/seg_refresh_timer.sv
// Digit-slot timer: cnt runs 0..REFRESH_DIV-1 per slot, idx walks the digits.
// Strobes mark the slot wrap, the frame wrap and the last guard cycle.
module seg_refresh_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4,
  localparam int CW = $clog2(REFRESH_DIV),
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_slot_wrap,
  output logic          o_frame_wrap,
  output logic          o_guard_end,
  output logic [IW-1:0] o_idx,
  output logic [IW-1:0] o_idx_nxt
);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;

  assign o_slot_wrap  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign o_frame_wrap = o_slot_wrap && (r_idx == IW'(NUM_DIGITS - 1));
  assign o_guard_end  = (r_cnt == CW'(GUARD_CYC - 1));
  assign o_idx        = r_idx;
  assign o_idx_nxt    = !o_slot_wrap  ? r_idx :
                        o_frame_wrap  ? '0    : r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= o_idx_nxt;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode display driving one shared
// decoder; new words are swapped in only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        host,
  output logic [3:0]            bcd,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (GUARD_CYC < 2 || GUARD_CYC >= REFRESH_DIV) begin : g_bad_guard
    $error("seg_scan_ctrl: GUARD_CYC must be in 2..REFRESH_DIV-1");
  end
  if (NUM_DIGITS < 1) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be at least 1");
  end

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic                  w_guard_end;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [W-1:0]          w_word_nxt;
  logic [NUM_DIGITS-1:0] w_sup;
  logic                  w_zero_above;
  logic [3:0]            w_nib;
  logic [3:0]            w_bcd_nxt;

  logic [W-1:0]          r_shadow;
  logic [W-1:0]          r_active;
  logic                  r_pending;
  logic                  r_ack;
  logic [3:0]            r_bcd;
  logic [NUM_DIGITS-1:0] r_an;

  seg_refresh_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYC   (GUARD_CYC)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .o_slot_wrap  (w_slot_wrap),
    .o_frame_wrap (w_frame_wrap),
    .o_guard_end  (w_guard_end),
    .o_idx        (w_idx),
    .o_idx_nxt    (w_idx_nxt)
  );

  // A load on the boundary edge itself bypasses the shadow register.
  assign w_word_nxt = !w_frame_wrap ? r_active :
                      host.load     ? host.digits_in :
                      r_pending     ? r_shadow : r_active;

  always_comb begin
    w_sup        = '0;
    w_zero_above = host.blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (w_word_nxt[4*k +: 4] != 4'h0) w_zero_above = 1'b0;
      w_sup[k] = w_zero_above;
    end
  end

  assign w_nib     = w_word_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_bcd_nxt = w_sup[w_idx_nxt] ? BLANK_BCD : w_nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '1;
      r_active  <= '1;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_bcd     <= BLANK_BCD;
      r_an      <= '1;
    end else begin
      r_ack <= w_frame_wrap && (r_pending || host.load);
      if (w_frame_wrap) begin
        r_active  <= w_word_nxt;
        r_pending <= 1'b0;
      end else if (host.load) begin
        r_shadow  <= host.digits_in;
        r_pending <= 1'b1;
      end
      // bcd changes with the anodes dark; anode turns on after the decoder settles.
      if (w_slot_wrap) begin
        r_bcd <= w_bcd_nxt;
        r_an  <= '1;
      end else if (w_guard_end) begin
        r_an <= ~(NUM_DIGITS'(1) << w_idx);
      end
    end
  end

  assign host.ack = r_ack;
  assign bcd      = r_bcd;
  assign an       = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FRAME = N * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd;
  logic [3:0] an;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) host_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .GUARD_CYC   (G)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host_if.slave),
    .bcd  (bcd),
    .an   (an)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles since reset, word shown this frame, newest loaded word.
  int          m_n;
  logic [15:0] m_word;
  logic [15:0] m_latest;
  bit          m_has;
  bit          m_ack;
  bit          m_lz;

  int ack_count;
  int ones_seen;
  bit cur_lz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    int          cnt;
    int          idx;
    logic [3:0]  exp_an;
    logic [15:0] upper;
    logic [3:0]  exp_bcd;
    cnt    = m_n % RD;
    idx    = (m_n / RD) % N;
    exp_an = (cnt < G) ? 4'hF : ~(4'b0001 << idx);
    upper  = m_word >> (4 * idx);
    exp_bcd = upper[3:0];
    if (m_lz && idx > 0 && upper == 16'h0) exp_bcd = 4'hF;
    chk("an", {28'h0, an}, {28'h0, exp_an});
    chk("bcd", {28'h0, bcd}, {28'h0, exp_bcd});
    chk("ack", {31'h0, host_if.ack}, {31'h0, m_ack});
    chk("an_onehot", {31'h0, ($countones(~an) <= 1)}, 32'h1);
    if (host_if.ack === 1'b1) ack_count++;
    if (bcd === 4'h1) ones_seen++;
  endtask

  task automatic step(input bit ld, input logic [15:0] w, input bit lz, input bit r);
    bit boundary;
    host_if.load      = ld;
    host_if.digits_in = w;
    host_if.blank_lz  = lz;
    rst               = r;
    @(posedge clk);
    if (r) begin
      m_n    = 0;
      m_word = 16'hFFFF;
      m_has  = 1'b0;
      m_ack  = 1'b0;
      m_lz   = 1'b0;
    end else begin
      boundary = (m_n % FRAME) == FRAME - 1;
      if (ld) begin
        m_latest = w;
        m_has    = 1'b1;
      end
      m_ack = 1'b0;
      if (boundary && m_has) begin
        m_word = m_latest;
        m_has  = 1'b0;
        m_ack  = 1'b1;
      end
      if (m_n % RD == RD - 1) m_lz = lz;
      m_n++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, cur_lz, 1'b0);
  endtask

  task automatic idle_until(input int phase);
    while (m_n % FRAME != phase) step(1'b0, 16'h0, cur_lz, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++)
      w[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    host_if.load      = 1'b0;
    host_if.digits_in = '0;
    host_if.blank_lz  = 1'b0;
    rst               = 1'b1;
    cur_lz            = 1'b0;
    m_n = 0; m_word = 16'hFFFF; m_latest = 16'hFFFF; m_has = 0; m_ack = 0; m_lz = 0;
    @(negedge clk);

    // Reset held, then blank frames with no ack.
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b1);
    ack_count = 0;
    idle(40);
    chk("t1_no_ack", ack_count, 0);

    // Single load: exactly one ack.
    ack_count = 0;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    idle(70);
    chk("t2_ack_once", ack_count, 1);

    // Leading-zero suppression.
    cur_lz = 1'b1;
    step(1'b1, 16'h0050, cur_lz, 1'b0);
    idle(70);
    step(1'b1, 16'h0000, cur_lz, 1'b0);
    idle(70);
    cur_lz = 1'b0;

    // Two loads in one frame: last one wins, one ack, first word never shown.
    idle_until(2);
    idle(FRAME);
    ack_count = 0;
    ones_seen = 0;
    step(1'b1, 16'h1111, cur_lz, 1'b0);
    idle(5);
    step(1'b1, 16'h2222, cur_lz, 1'b0);
    idle(2 * FRAME);
    chk("t4_ack_once", ack_count, 1);
    chk("t4_no_1111", ones_seen, 0);

    // Load on the boundary edge itself.
    idle_until(FRAME - 1);
    step(1'b1, 16'h9876, cur_lz, 1'b0);
    chk("t5_ack_next", {31'h0, host_if.ack}, 32'h1);
    idle(FRAME);

    // Reset with a load pending discards it.
    idle_until(10);
    step(1'b1, 16'h4321, cur_lz, 1'b0);
    idle(3);
    step(1'b0, 16'h0, cur_lz, 1'b1);
    ack_count = 0;
    idle(2 * FRAME + 5);
    chk("t6_no_ack", ack_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      bit r;
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      ld = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 499) == 0);
      step(ld, rand_word(), cur_lz, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
